// File: rtl/regfile_mp.sv
// regfile_mp - parametrised multi-read-port integer register file.
//
// Sits between decode (read addresses) and writeback (write port). After
// reset a hardware sweep writes zero to every register, one per cycle, and
// raises ready when the sweep has finished. Writes are accepted only once
// ready is high. Every read port has one cycle of latency and is registered.
//
// Parameters:
//   XLEN     data width in bits
//   NREGS    number of registers (>= 2, need not be a power of two)
//   NREAD    number of read ports (1..8)
//   ZERO_REG 1: register 0 always reads as zero and writes to it are dropped
//
// Ports:
//   clk           rising-edge clock for all state
//   rst           asynchronous active-high reset
//   write_enable  write request this cycle
//   write_addr    write register index (AW bits)
//   data          write data (XLEN bits)
//   read_addr     packed read indices, port p at [p*AW +: AW]
//   out           packed registered read data, port p at [p*XLEN +: XLEN]
//   ready         high once the clear sweep has finished
//
// Optional feature, macro REGFILE_MP_BYPASS_EN:
//   defined   - a write that is actually performed is forwarded to any read
//               port reading the same index in the same cycle (write-first).
//   undefined - read-first: the read returns the value held before the write.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [AW-1:0]         write_addr,
  input  logic [XLEN-1:0]       data,
  input  logic [NREAD*AW-1:0]   read_addr,
  output logic [NREAD*XLEN-1:0] out,
  output logic                  ready
);

  localparam logic STATE_CLEAR = 1'b0;
  localparam logic STATE_RUN   = 1'b1;

  // One extra bit so NREGS itself is representable when it is a power of two.
  localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST_A  = AW'(NREGS - 1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [AW-1:0] ZERO_A  = {AW{1'b0}};

  logic                  state_q, state_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic                  ready_q, ready_d;
  logic [NREAD*XLEN-1:0] out_q, out_d;
  logic [XLEN-1:0]       mem_q [NREGS];

  logic                  user_wr_s;
  logic                  mem_we_s;
  logic [AW-1:0]         mem_waddr_s;
  logic [XLEN-1:0]       mem_wdata_s;
  logic [AW-1:0]         rd_addr_s;

  // Indices at or above NREGS address no storage (no wrap or aliasing).
  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W);
  endfunction

  // Decide whether the writeback request is actually performed this cycle.
  always_comb begin
    user_wr_s = 1'b0;
    if ((state_q == STATE_RUN) && write_enable && in_range(write_addr) &&
        !((ZERO_REG != 0) && (write_addr == ZERO_A))) begin
      user_wr_s = 1'b1;
    end else begin
      user_wr_s = 1'b0;
    end
  end

  // Sweep FSM and selection of the single storage write port.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ready_d     = ready_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = write_addr;
    mem_wdata_s = data;
    case (state_q)
      STATE_CLEAR: begin
        // The sweep owns the write port; user writes are dropped.
        mem_we_s    = 1'b1;
        mem_waddr_s = ptr_q;
        mem_wdata_s = {XLEN{1'b0}};
        if (ptr_q == LAST_A) begin
          state_d = STATE_RUN;
          ready_d = 1'b1;
        end else begin
          ptr_d = ptr_q + ONE_A;
        end
      end
      STATE_RUN: begin
        ready_d  = 1'b1;
        mem_we_s = user_wr_s;
      end
      default: begin
        state_d = STATE_CLEAR;
        ptr_d   = ZERO_A;
        ready_d = 1'b0;
      end
    endcase
  end

  // Next-cycle read data for every port.
  always_comb begin
    out_d     = {(NREAD*XLEN){1'b0}};
    rd_addr_s = ZERO_A;
    for (int p = 0; p < NREAD; p++) begin
      rd_addr_s = read_addr[p*AW +: AW];
      if (!in_range(rd_addr_s)) begin
        out_d[p*XLEN +: XLEN] = {XLEN{1'b0}};
      end else if ((ZERO_REG != 0) && (rd_addr_s == ZERO_A)) begin
        out_d[p*XLEN +: XLEN] = {XLEN{1'b0}};
`ifdef REGFILE_MP_BYPASS_EN
      end else if (user_wr_s && (write_addr == rd_addr_s)) begin
        // Only writes that really land are forwarded.
        out_d[p*XLEN +: XLEN] = data;
`endif
      end else begin
        out_d[p*XLEN +: XLEN] = mem_q[rd_addr_s];
      end
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STATE_CLEAR;
      ptr_q   <= ZERO_A;
      ready_q <= 1'b0;
      out_q   <= {(NREAD*XLEN){1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      out_q   <= out_d;
    end
  end

  // Storage array; cleared by the sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign out   = out_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt;

  // Instance 0: defaults (32 regs, 2 read ports, hardwired zero).
  logic        rst0;
  logic        we0;
  logic [4:0]  wa0;
  logic [31:0] wd0;
  logic [9:0]  ra0;
  logic [63:0] out0;
  logic        rdy0;

  // Instance 1: 20 regs (non power of two), 4 read ports, r0 ordinary.
  logic         rst1;
  logic         we1;
  logic [4:0]   wa1;
  logic [31:0]  wd1;
  logic [19:0]  ra1;
  logic [127:0] out1;
  logic         rdy1;

  regfile_mp u0 (
    .clk(clk), .rst(rst0), .write_enable(we0), .write_addr(wa0),
    .data(wd0), .read_addr(ra0), .out(out0), .ready(rdy0)
  );

  regfile_mp #(.XLEN(32), .NREGS(20), .NREAD(4), .ZERO_REG(0)) u1 (
    .clk(clk), .rst(rst1), .write_enable(we1), .write_addr(wa1),
    .data(wd1), .read_addr(ra1), .out(out1), .ready(rdy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] p0(input int p);
    return out0[32*p +: 32];
  endfunction

  function automatic logic [31:0] p1(input int p);
    return out1[32*p +: 32];
  endfunction

  initial begin
    rst0 = 1'b1; we0 = 1'b0; wa0 = 5'd0; wd0 = 32'd0; ra0 = 10'd0;
    rst1 = 1'b1; we1 = 1'b0; wa1 = 5'd0; wd1 = 32'd0; ra1 = 20'd0;

    // Reset held 3 cycles
    repeat (3) step();
    check("rst_ready", {31'd0, rdy0}, 32'd0);
    check("rst_out_p0", p0(0), 32'd0);
    check("rst_out_p1", p0(1), 32'd0);

    // Release; try to write r1 during the whole sweep (must be dropped)
    rst0 = 1'b0;
    we0 = 1'b1; wa0 = 5'd1; wd0 = 32'hCAFE_F00D;
    cnt = 0;
    while (!rdy0 && cnt < 100) begin
      step();
      cnt++;
    end
    we0 = 1'b0;
    check("sweep_len_32", cnt, 32'd32);

    // All registers read zero after the sweep
    for (int i = 0; i < 32; i++) begin
      ra0 = {5'(31 - i), 5'(i)};
      step();
      check($sformatf("clr_r%0d", i), p0(0), 32'd0);
      check($sformatf("clr_r%0d", 31 - i), p0(1), 32'd0);
    end

    // Write r5 then read it on both ports
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF;
    step();
    we0 = 1'b0; ra0 = {5'd5, 5'd5};
    step();
    check("r5_p0", p0(0), 32'hDEAD_BEEF);
    check("r5_p1", p0(1), 32'hDEAD_BEEF);

    // Hardwired zero register
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
    step();
    we0 = 1'b0; ra0 = {5'd0, 5'd0};
    step();
    check("r0_zero_p0", p0(0), 32'd0);
    check("r0_zero_p1", p0(1), 32'd0);

    // Collision: r7 holds 1, written 0x12345678 while being read
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h0000_0001;
    step();
    wd0 = 32'h1234_5678; ra0 = {5'd5, 5'd7};
    step();
    we0 = 1'b0;
`ifdef REGFILE_MP_BYPASS_EN
    check("collide_r7", p0(0), 32'h1234_5678);
`else
    check("collide_r7", p0(0), 32'h0000_0001);
`endif
    check("collide_other", p0(1), 32'hDEAD_BEEF);
    step();
    check("r7_after", p0(0), 32'h1234_5678);

    // Suppressed x0 write never forwards
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h7777_7777; ra0 = {5'd7, 5'd0};
    step();
    we0 = 1'b0;
    check("x0_no_fwd", p0(0), 32'd0);
    check("x0_r7", p0(1), 32'h1234_5678);

    // Reset in RUN: asynchronous clear of ready and out
    rst0 = 1'b1;
    #1;
    check("run_rst_ready", {31'd0, rdy0}, 32'd0);
    check("run_rst_out", p0(0), 32'd0);
    step();
    rst0 = 1'b0;

    // Instance 1: sweep of 20 cycles
    rst1 = 1'b0;
    cnt = 0;
    while (!rdy1 && cnt < 100) begin
      step();
      cnt++;
    end
    check("sweep_len_20", cnt, 32'd20);

    // Fill every register with A5A5A5A5
    for (int i = 0; i < 20; i++) begin
      we1 = 1'b1; wa1 = 5'(i); wd1 = 32'hA5A5_A5A5;
      step();
    end
    we1 = 1'b0;
    ra1 = {5'd0, 5'd1, 5'd10, 5'd19};
    step();
    for (int p = 0; p < 4; p++) check($sformatf("fill_p%0d", p), p1(p), 32'hA5A5_A5A5);

    // Reset pulse, second pulse 5 cycles into the sweep
    rst1 = 1'b1;
    #1;
    check("mid_rst_out", p1(0), 32'd0);
    step();
    rst1 = 1'b0;
    repeat (5) step();
    rst1 = 1'b1;
    step();
    check("mid_rst_ready", {31'd0, rdy1}, 32'd0);
    rst1 = 1'b0;
    we1 = 1'b1; wa1 = 5'd2; wd1 = 32'h0000_0BAD;
    cnt = 0;
    while (!rdy1 && cnt < 100) begin
      step();
      cnt++;
    end
    we1 = 1'b0;
    check("resweep_len_20", cnt, 32'd20);

    // All 20 registers cleared, including r2 written during the sweep
    for (int i = 0; i < 5; i++) begin
      ra1 = {5'(4*i + 3), 5'(4*i + 2), 5'(4*i + 1), 5'(4*i)};
      step();
      for (int p = 0; p < 4; p++) check($sformatf("reclr_r%0d", 4*i + p), p1(p), 32'd0);
    end

    // Out-of-range writes dropped, no aliasing onto r10 or r14
    we1 = 1'b1; wa1 = 5'd30; wd1 = 32'h0000_0055;
    step();
    wa1 = 5'd20; wd1 = 32'h0000_0066;
    step();
    we1 = 1'b0;
    ra1 = {5'd10, 5'd14, 5'd20, 5'd30};
    step();
    check("oor_r30", p1(0), 32'd0);
    check("oor_r20", p1(1), 32'd0);
    check("alias_r14", p1(2), 32'd0);
    check("alias_r10", p1(3), 32'd0);

    // Distinct data on four ports; r0 is ordinary storage here
    we1 = 1'b1; wa1 = 5'd0;  wd1 = 32'hFFFF_FFFF; step();
    wa1 = 5'd3;  wd1 = 32'h0000_0033; step();
    wa1 = 5'd11; wd1 = 32'h0000_1111; step();
    wa1 = 5'd19; wd1 = 32'h0000_1919; step();
    we1 = 1'b0;
    ra1 = {5'd0, 5'd3, 5'd11, 5'd19};
    step();
    check("ports_r19", p1(0), 32'h0000_1919);
    check("ports_r11", p1(1), 32'h0000_1111);
    check("ports_r3",  p1(2), 32'h0000_0033);
    check("ports_r0",  p1(3), 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
